// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer: drain FSM encodings
// and the default payload width.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        D_IDLE      = 2'd0,
        D_LAUNCH    = 2'd1,
        D_WAIT_BUSY = 2'd2,
        D_WAIT_DONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with count-derived full/empty and a flush that discards
// everything stored but not yet popped.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Flush outranks both ports so a simultaneous write or pop is discarded.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: valid/ready write side, drain FSM feeding the UART
// transmitter one byte per enable pulse, paced by the transmitter busy flag.
//
// state        | meaning
// D_IDLE       | waiting for a stored byte and an idle transmitter
// D_LAUNCH     | uart_tx_en high for this single cycle
// D_WAIT_BUSY  | waiting for the transmitter to register busy
// D_WAIT_DONE  | waiting for the stop bit to finish (busy low)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              uart_tx_en,
    output logic [DATA_W-1:0] uart_tx_data,
    input  logic              uart_tx_busy
);

    drain_state_t      state;
    drain_state_t      state_nxt;
    logic              launch;
    logic [DATA_W-1:0] rd_data;

    assign wr_ready = !full;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_valid),
        .pop     (launch),
        .flush   (flush),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        unique case (state)
            D_IDLE: begin
                // A flush on the launch edge wins: nothing is popped or sent.
                if (!empty && !uart_tx_busy && !flush) begin
                    launch    = 1'b1;
                    state_nxt = D_LAUNCH;
                end
            end
            D_LAUNCH:    state_nxt = D_WAIT_BUSY;
            D_WAIT_BUSY: if (uart_tx_busy) state_nxt = D_WAIT_DONE;
            D_WAIT_DONE: if (!uart_tx_busy) state_nxt = D_IDLE;
            default:     state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= D_IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state      <= state_nxt;
            uart_tx_en <= launch;
            if (launch) begin
                uart_tx_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed stimulus queues expected bytes,
// a monitor checks every launch pulse; a small transmitter model drives busy.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int TX_LEN = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       hold_busy = 1'b0;
    int         tx_cnt = 0;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_launch = 0;
    logic [7:0] exp_q[$];

    assign uart_tx_busy = hold_busy || (tx_cnt != 0);

    uart_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .flush        (flush),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy rises the cycle after the enable pulse.
    initial begin
        logic en_s;
        forever begin
            @(negedge clk);
            en_s = uart_tx_en;
            @(posedge clk);
            #1;
            if (reset)          tx_cnt = 0;
            else if (en_s)      tx_cnt = TX_LEN;
            else if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
        end
    end

    // Monitor: every launch must be a single-cycle pulse carrying the oldest expected byte.
    initial begin
        logic prev_en;
        logic [7:0] exp_b;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx_en) begin
                check("en_single_cycle", 32'(prev_en), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 32'(uart_tx_data), 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_data", 32'(uart_tx_data), 32'(exp_b));
                end
                n_launch++;
            end
            prev_en = uart_tx_en;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (count == 0 && !uart_tx_busy && dut.state == D_IDLE && !uart_tx_en) done = 1'b1;
        end
        check({name, "_idle"}, 32'(done), 32'd1);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int idx;
        logic ok;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_tx_en", 32'(uart_tx_en), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'd0);

        // Single byte: two edges from write to launch
        write_byte(8'hA5);
        @(negedge clk);
        wr_valid = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_en_early", 32'(uart_tx_en), 32'd0);
        @(negedge clk);
        check("single_en", 32'(uart_tx_en), 32'd1);
        check("single_data", 32'(uart_tx_data), 32'hA5);
        check("single_count0", 32'(count), 32'd0);
        @(negedge clk);
        check("single_en_fall", 32'(uart_tx_en), 32'd0);
        wait_idle("single");
        check("single_data_held", 32'(uart_tx_data), 32'hA5);

        // Burst to full with the transmitter held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        @(negedge clk);
        check("burst_full", 32'(full), 32'd1);
        check("burst_wr_ready", 32'(wr_ready), 32'd0);
        check("burst_count", 32'(count), 32'd16);
        wr_data = 8'hEE;
        @(negedge clk);
        wr_valid = 1'b0;
        check("burst_17th_rejected", 32'(count), 32'd16);
        check("burst_no_launch", 32'(n_launch), 32'd1);
        hold_busy = 1'b0;
        wait_idle("burst");
        check("burst_launches", 32'(n_launch), 32'd17);

        // Push and pop on the same edge
        hold_busy = 1'b1;
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        @(negedge clk);
        check("simul_count_pre", 32'(count), 32'd3);
        hold_busy = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        wr_valid = 1'b0;
        check("simul_count_post", 32'(count), 32'd3);
        check("simul_en", 32'(uart_tx_en), 32'd1);
        wait_idle("simul");

        // Wrap: 40 bytes through a 16-deep FIFO
        base = n_launch;
        idx  = 0;
        for (int k = 0; k < 2000 && idx < 40; k++) begin
            @(negedge clk);
            if (wr_ready) begin
                wr_valid = 1'b1;
                wr_data  = 8'((idx * 7) % 256);
                exp_q.push_back(8'((idx * 7) % 256));
                idx++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("wrap_all_written", 32'(idx), 32'd40);
        wait_idle("wrap");
        check("wrap_launches", 32'(n_launch - base), 32'd40);

        // Flush while 0x11 is in flight; simultaneous write is discarded
        base = n_launch;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        @(negedge clk);
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (uart_tx_busy) ok = 1'b1;
            else @(negedge clk);
        end
        check("flush_busy_seen", 32'(ok), 32'd1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h44;
        exp_q.delete();
        @(negedge clk);
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_wr_ready", 32'(wr_ready), 32'd1);
        wait_idle("flush");
        check("flush_launches", 32'(n_launch - base), 32'd1);
        check("flush_last_data", 32'(uart_tx_data), 32'h11);

        // Reset in D_WAIT_DONE with five bytes stored
        for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
        @(negedge clk);
        wr_valid = 1'b0;
        check("rstmid_count", 32'(count), 32'd5);
        check("rstmid_state", 32'(dut.state), 32'(D_WAIT_DONE));
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_count0", 32'(count), 32'd0);
        check("rstmid_en", 32'(uart_tx_en), 32'd0);
        check("rstmid_state_idle", 32'(dut.state), 32'(D_IDLE));
        check("rstmid_wr_ready", 32'(wr_ready), 32'd1);
        wait_idle("rstmid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the system over a valid/ready interface and stores them in a synchronous FIFO. A drain FSM hands bytes to the transmitter one at a time using the transmitter's one-cycle enable pulse and its busy flag. Producers can burst bytes without tracking the serial line timing.

Parameters:
DATA_W, 8, payload width; must equal the transmitter's PAYLOAD_BITS.
DEPTH, 16, FIFO entries; power of two, >= 2.
ADDR_W, $clog2(DEPTH), localparam; pointer width.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  producer has a byte on wr_data.
wr_ready  output  1  FIFO can accept a byte; equals !full.
wr_data  input  DATA_W  byte to enqueue.
flush  input  1  synchronous clear of stored (not yet launched) bytes.
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
uart_tx_en  output  1  one-cycle launch pulse to the transmitter.
uart_tx_data  output  DATA_W  byte presented with uart_tx_en.
uart_tx_busy  input  1  transmitter busy; rises the cycle after uart_tx_en and falls when the stop bit completes.

Behaviour:
- Reset (clk edge with reset=1): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, wr_ready=1, uart_tx_en=0, uart_tx_data=0, drain FSM=D_IDLE. Reset mid-transfer abandons the byte in flight. The transmitter is reset by the same signal.
- Write: a byte is accepted on an edge with wr_valid && wr_ready. It is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH. When full, wr_ready=0 and nothing is written; no data is dropped silently.
- Pop: occurs only on the D_IDLE->D_LAUNCH transition. rd_ptr increments, wrapping modulo DEPTH.
- Count: a push and a pop on the same edge leave count unchanged. A push at full cannot occur. A pop at empty cannot occur.
- Drain FSM states:
  - D_IDLE: if !empty && !uart_tx_busy, go to D_LAUNCH. On that edge, register uart_tx_data <= mem[rd_ptr], set uart_tx_en <= 1, and pop.
  - D_LAUNCH: uart_tx_en=1 for exactly this cycle. The next edge clears uart_tx_en and goes to D_WAIT_BUSY.
  - D_WAIT_BUSY: wait until uart_tx_busy=1, then go to D_WAIT_DONE. This protects against launching twice before busy registers.
  - D_WAIT_DONE: wait until uart_tx_busy=0, then go to D_IDLE.
  - Unreachable encodings go to D_IDLE.
- Latency: a byte written into an empty FIFO with the transmitter idle is written on edge N. empty falls after edge N, the launch edge is N+1, and uart_tx_en is high in the cycle after N+1. This gives two edges from write to launch.
- Back-to-back: the next launch is no earlier than 1 cycle after busy falls.
- uart_tx_data holds its value until the next launch and is not cleared on idle.
- flush: on the edge, rd_ptr <= wr_ptr and count <= 0. A byte already launched is unaffected and the FSM continues. flush has priority over a simultaneous write, so the write is discarded. wr_ready stays 1. A flush coinciding with a D_IDLE launch: flush wins and no launch occurs.
- Wrap: the pointers are ADDR_W bits. full/empty are derived from the ADDR_W+1-bit count, not from pointer comparison.
- No combinational path from wr_valid to uart_tx_en. wr_ready depends only on registered count.

Decomposition:
- Shared package uart_pkg: drain state encodings (D_IDLE=0, D_LAUNCH=1, D_WAIT_BUSY=2, D_WAIT_DONE=3) and the default DATA_W=8.
- One sub-module, uart_sync_fifo: storage array, pointers, count, full/empty, and flush.
- The top level contains the drain FSM and the transmitter handshake registers.

Test Plan:
- Single byte: reset, then write 0xA5 with the transmitter idle -> uart_tx_en high exactly 1 cycle, 2 edges after the write, with uart_tx_data=0xA5. count returns to 0.
- Burst: write 0x00..0x0F back-to-back with uart_tx_busy held high externally -> full=1 and wr_ready=0 after the 16th write. A 17th wr_valid is not accepted. Release busy -> bytes launch in order 0x00..0x0F, one en pulse per busy fall.
- Simultaneous: at count=3, write 0x5A on the same edge as a launch -> count stays 3 and 0x5A emerges fourth.
- Wrap: write and drain 40 bytes (pattern i*7 mod 256) through DEPTH=16 -> output order and values match the input; no duplicated or missing bytes.
- Flush: queue 0x11,0x22,0x33; assert flush while 0x11 is in flight -> 0x11 completes, and no en pulse for 0x22 or 0x33; count=0, empty=1.
- Reset mid-operation: assert reset in D_WAIT_DONE with count=5 -> next cycle count=0, uart_tx_en=0, FSM=D_IDLE, wr_ready=1.
